// File: rtl/rtc_bus_master_pkg.sv
// Shared types and constants for the RTC multiplexed-bus initiator.
package rtc_bus_master_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TIMER_W = 8;
  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] S_IDLE = 4'd0;
  localparam logic [STATE_W-1:0] S_AS   = 4'd1;
  localparam logic [STATE_W-1:0] S_AP   = 4'd2;
  localparam logic [STATE_W-1:0] S_AH   = 4'd3;
  localparam logic [STATE_W-1:0] S_DS   = 4'd4;
  localparam logic [STATE_W-1:0] S_DP   = 4'd5;
  localparam logic [STATE_W-1:0] S_DH   = 4'd6;
  localparam logic [STATE_W-1:0] S_DONE = 4'd7;
  localparam logic [STATE_W-1:0] S_TURN = 4'd8;

  localparam logic OP_RD = 1'b1;
  localparam logic OP_WR = 1'b0;

  localparam int unsigned T_SETUP_DEF = 2;
  localparam int unsigned T_PULSE_DEF = 10;
  localparam int unsigned T_HOLD_DEF  = 2;
  localparam int unsigned T_TURN_DEF  = 4;

  // Request captured when start is accepted
  typedef struct packed {
    logic              rd_wr;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  function automatic logic is_addr_phase(input logic [STATE_W-1:0] s);
    return s inside {S_AS, S_AP, S_AH};
  endfunction

  function automatic logic is_data_phase(input logic [STATE_W-1:0] s);
    return s inside {S_DS, S_DP, S_DH};
  endfunction

endpackage

// File: rtl/rtc_bus_master_timer.sv
// 8-bit loadable down-counter; expired_o is high during the cycle the count is 1.
module rtc_bus_master_timer
  import rtc_bus_master_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               expired_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               expired_q, expired_d;

  // Expired is registered from the next count so it lines up with cnt_q == 1
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
    expired_d = (cnt_d == TIMER_W'(1));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/rtc_bus_master.sv
// Initiator for the RTC multiplexed address/data bus: one read or write per start.
// Define RTC_BUS_TURNAROUND_EN to insert T_TURN idle cycles after each done.
module rtc_bus_master
  import rtc_bus_master_pkg::*;
#(
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_PULSE = T_PULSE_DEF,
  parameter int unsigned T_HOLD  = T_HOLD_DEF,
  parameter int unsigned T_TURN  = T_TURN_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              rd_wr_i,
  input  logic [DATA_W-1:0] addr_in_i,
  input  logic [DATA_W-1:0] data_wr_i,
  output logic [DATA_W-1:0] data_rd_o,
  output logic              busy_o,
  output logic              done_o,
  inout  wire  [DATA_W-1:0] ad_io,
  output logic              cs_n_o,
  output logic              rd_n_o,
  output logic              wr_n_o,
  output logic              a_d_o
);

  logic [STATE_W-1:0] state_q, state_d;
  req_t               req_q, req_d;
  logic [DATA_W-1:0]  data_rd_q, data_rd_d;
  logic [DATA_W-1:0]  ad_q, ad_d;
  logic               ad_oe_q, ad_oe_d;
  logic               cs_n_q, cs_n_d;
  logic               rd_n_q, rd_n_d;
  logic               wr_n_q, wr_n_d;
  logic               a_d_q, a_d_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timer_load_c;
  logic [TIMER_W-1:0] timer_val_c;
  logic               expired;

  function automatic logic [TIMER_W-1:0] dwell(input logic [STATE_W-1:0] s);
    case (s)
      S_AS, S_DS: return TIMER_W'(T_SETUP);
      S_AP, S_DP: return TIMER_W'(T_PULSE);
      S_AH, S_DH: return TIMER_W'(T_HOLD);
      S_DONE:     return TIMER_W'(1);
      S_TURN:     return TIMER_W'(T_TURN);
      default:    return '0;
    endcase
  endfunction

  rtc_bus_master_timer u_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (timer_load_c),
    .load_val_i (timer_val_c),
    .expired_o  (expired)
  );

  // Next state, request capture, read sampling and pin values for the next cycle
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    data_rd_d = data_rd_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_AS;
          req_d   = '{rd_wr: rd_wr_i, addr: addr_in_i, data: data_wr_i};
        end
      end
      S_AS: if (expired) state_d = S_AP;
      S_AP: if (expired) state_d = S_AH;
      S_AH: if (expired) state_d = S_DS;
      S_DS: if (expired) state_d = S_DP;
      S_DP: begin
        if (expired) begin
          state_d = S_DH;
          if (req_q.rd_wr == OP_RD) data_rd_d = ad_io;
        end
      end
      S_DH: if (expired) state_d = S_DONE;
      S_DONE: begin
        if (expired) begin
`ifdef RTC_BUS_TURNAROUND_EN
          state_d = S_TURN;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_TURN: if (expired) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    timer_load_c = (state_d != state_q);
    timer_val_c  = dwell(state_d);

    // The address phase always uses wr_n as the address latch strobe
    cs_n_d  = ~(is_addr_phase(state_d) | is_data_phase(state_d));
    a_d_d   = ~is_addr_phase(state_d);
    wr_n_d  = ~((state_d == S_AP) | ((state_d == S_DP) & (req_d.rd_wr == OP_WR)));
    rd_n_d  = ~((state_d == S_DP) & (req_d.rd_wr == OP_RD));
    ad_oe_d = is_addr_phase(state_d) | (is_data_phase(state_d) & (req_d.rd_wr == OP_WR));
    ad_d    = is_addr_phase(state_d) ? req_d.addr : req_d.data;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      data_rd_q <= '0;
      ad_q      <= '0;
      ad_oe_q   <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      a_d_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      data_rd_q <= data_rd_d;
      ad_q      <= ad_d;
      ad_oe_q   <= ad_oe_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      a_d_q     <= a_d_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ad_io     = ad_oe_q ? ad_q : {DATA_W{1'bz}};
  assign data_rd_o = data_rd_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign cs_n_o    = cs_n_q;
  assign rd_n_o    = rd_n_q;
  assign wr_n_o    = wr_n_q;
  assign a_d_o     = a_d_q;

endmodule

// File: tb/tb_rtc_bus_master.sv
// Scoreboard bench for rtc_bus_master: driver queues expected transactions, negedge monitor checks pins.
module tb_rtc_bus_master;

  localparam int unsigned LAT     = 29;
  localparam int unsigned T_PULSE = 10;
`ifdef RTC_BUS_TURNAROUND_EN
  localparam int unsigned GAP = 34;
`else
  localparam int unsigned GAP = 30;
`endif

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic       rd_wr_i = 1'b0;
  logic [7:0] addr_in_i = 8'h00;
  logic [7:0] data_wr_i = 8'h00;
  logic [7:0] rd_val = 8'h13;
  logic [7:0] data_rd_o;
  logic       busy_o, done_o, cs_n_o, rd_n_o, wr_n_o, a_d_o;
  wire  [7:0] ad;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] data;
    int         start_cyc;
  } exp_t;
  exp_t exp_q[$];

  rtc_bus_master dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .rd_wr_i   (rd_wr_i),
    .addr_in_i (addr_in_i),
    .data_wr_i (data_wr_i),
    .data_rd_o (data_rd_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .ad_io     (ad),
    .cs_n_o    (cs_n_o),
    .rd_n_o    (rd_n_o),
    .wr_n_o    (wr_n_o),
    .a_d_o     (a_d_o)
  );

  // RTC model: answers reads while rd_n is low; a released bus reads as 8'hFF
  assign ad = (rd_n_o == 1'b0) ? rd_val : 8'bz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (ad[gi]);
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic rd, input logic [7:0] a, input logic [7:0] d);
    rd_wr_i   = rd;
    addr_in_i = a;
    data_wr_i = d;
    start_i   = 1'b1;
    exp_q.push_back('{rd, a, d, cyc});
    tick();
    start_i   = 1'b0;
    addr_in_i = ~a;
    data_wr_i = ~d;
    rd_wr_i   = ~rd;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 100) begin
      tick();
      n++;
    end
    chk("idle_within_bound", 32'(busy_o), 0);
  endtask

  // Monitor
  int   wcnt = 0;
  int   rcnt = 0;
  int   wstb = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (reset_i) begin
      wcnt = 0;
      rcnt = 0;
      wstb = 0;
    end else begin
      if (cs_n_o) begin
        chk("idle_strobes", 32'({rd_n_o, wr_n_o}), 32'(2'b11));
      end else begin
        chk("strobe_overlap", 32'(!rd_n_o && !wr_n_o), 0);
        chk("request_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur = exp_q[0];
          if (!a_d_o)        chk("addr_on_bus", 32'(ad), 32'(cur.addr));
          else if (!cur.rd)  chk("wdata_on_bus", 32'(ad), 32'(cur.data));
          else if (rd_n_o)   chk("bus_released", 32'(ad), 32'hFF);
          else               chk("rd_drive_clean", 32'(ad), 32'(rd_val));
          if (!wr_n_o && wcnt == 0) begin
            if (wstb == 0) begin
              chk("ap_strobe_phase", 32'(a_d_o), 0);
            end else begin
              chk("dp_strobe_phase", 32'(a_d_o), 1);
              chk("dp_strobe_is_write", 32'(cur.rd), 0);
            end
            wstb++;
          end
          if (!rd_n_o && rcnt == 0) chk("rd_strobe_is_read", 32'(cur.rd), 1);
        end
      end
      if (!wr_n_o) wcnt++;
      else if (wcnt != 0) begin
        chk("wr_width", 32'(wcnt), T_PULSE);
        wcnt = 0;
      end
      if (!rd_n_o) rcnt++;
      else if (rcnt != 0) begin
        chk("rd_width", 32'(rcnt), T_PULSE);
        rcnt = 0;
      end
      if (done_o) begin
        chk("done_has_request", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          chk("done_latency", 32'(cyc - cur.start_cyc), LAT);
          chk("wr_strobe_count", 32'(wstb), cur.rd ? 32'd1 : 32'd2);
          chk("busy_at_done", 32'(busy_o), 1);
          if (cur.rd) chk("read_data", 32'(data_rd_o), 32'(rd_val));
        end
        wstb = 0;
      end
    end
  end

  initial begin
    int c;
    int n;
    repeat (3) tick();
    chk("rst_pins", 32'({cs_n_o, rd_n_o, wr_n_o, a_d_o}), 32'hF);
    chk("rst_busy_done", 32'({busy_o, done_o}), 0);
    chk("rst_data_rd", 32'(data_rd_o), 0);
    chk("rst_bus", 32'(ad), 32'hFF);
    reset_i = 1'b0;
    tick();

    issue(1'b0, 8'h21, 8'h59);
    wait_idle();

    rd_val = 8'h13;
    issue(1'b1, 8'h22, 8'h00);
    wait_idle();

    // Starts during a transaction are dropped
    c = cyc;
    issue(1'b0, 8'h30, 8'hA5);
    while (cyc < c + 5) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (cyc < c + 12) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_idle();
    chk("data_rd_held", 32'(data_rd_o), 32'h13);
    rd_val = 8'h7E;
    issue(1'b1, 8'h31, 8'h00);
    wait_idle();

    // Reset during the data strobe of a write
    issue(1'b0, 8'h40, 8'h3C);
    n = 0;
    while (!(a_d_o && !wr_n_o) && n < 60) begin
      tick();
      n++;
    end
    chk("reached_dp", 32'(a_d_o && !wr_n_o), 1);
    reset_i = 1'b1;
    tick();
    chk("midrst_pins", 32'({cs_n_o, rd_n_o, wr_n_o}), 32'h7);
    chk("midrst_bus", 32'(ad), 32'hFF);
    chk("midrst_busy_done", 32'({busy_o, done_o}), 0);
    chk("midrst_data_rd", 32'(data_rd_o), 0);
    exp_q.delete();
    reset_i = 1'b0;
    repeat (2) tick();

    // start held high: two transactions GAP cycles apart
    c = cyc;
    rd_wr_i   = 1'b0;
    addr_in_i = 8'h50;
    data_wr_i = 8'h66;
    exp_q.push_back('{1'b0, 8'h50, 8'h66, c});
    exp_q.push_back('{1'b0, 8'h50, 8'h66, c + int'(GAP)});
    start_i = 1'b1;
    while (cyc < c + int'(GAP) + 1) tick();
    start_i = 1'b0;
    wait_idle();
    repeat (10) tick();

    chk("all_done", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
